// File: rtl/set_pkg.sv
// Shared types for the SET job loader: job descriptor, mode encoding,
// dispatcher states and descriptor byte count.
package set_pkg;

  localparam int JOB_BYTES = 5;
  localparam int JOB_W     = 38;

  typedef enum logic [1:0] {
    MODE_A   = 2'd0,
    MODE_AND = 2'd1,
    MODE_XOR = 2'd2
  } mode_e;

  // Encoding 3 has no meaning to SET; jobs carrying it are discarded.
  localparam logic [1:0] MODE_INVALID = 2'd3;

  typedef struct packed {
    logic [23:0] central;
    logic [11:0] radius;
    logic [1:0]  mode;
  } job_t;

  typedef enum logic [1:0] {
    D_IDLE,
    D_ISSUE,
    D_WAIT,
    D_HOLD
  } disp_e;

  function automatic logic mode_ok(input logic [1:0] m);
    return m != MODE_INVALID;
  endfunction

endpackage

// File: rtl/set_job_fifo.sv
// Synchronous job FIFO with full/empty/level. Pointers carry one extra
// wrap bit so full and empty are distinguished without a separate counter.
module set_job_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 42,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;
  logic         do_push, do_pop;

  assign level_o = wptr_q - rptr_q;
  assign full_o  = (level_o == (AW+1)'(DEPTH));
  assign empty_o = (wptr_q == rptr_q);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer next-state.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  // Pointer registers; reset empties the queue.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage array; contents are only observed when non-empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/set_job_loader.sv
// Feeder for the SET circle-count engine. Packs 5-byte descriptors into
// jobs, queues them, dispatches one at a time over en/busy and returns each
// result with its job tag on a ready/valid port.
// Optional: define SET_LDR_TIMEOUT_EN to abandon a job after TIMEOUT cycles
// without set_valid (result FF with res_timeout set).
module set_job_loader
  import set_pkg::*;
#(
  parameter  int DEPTH   = 4,
  parameter  int TAG_W   = 4,
  parameter  int TIMEOUT = 256,
  localparam int LVL_W   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             set_busy,
  input  logic             set_valid,
  input  logic [7:0]       set_candidate,
  output logic             set_en,
  output logic [23:0]      set_central,
  output logic [11:0]      set_radius,
  output logic [1:0]       set_mode,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_candidate,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_timeout,
  output logic             err_mode,
  output logic [LVL_W-1:0] fifo_level
);

  localparam int FW = JOB_W + TAG_W;

  // ---------------- byte assembly ----------------
  logic [2:0]       byte_cnt_q;
  logic [23:0]      central_q;
  logic [7:0]       rad_hi_q;
  logic [TAG_W-1:0] in_tag_q;
  logic             err_q;
  logic             b_acc, last_byte, push;
  logic             fifo_full, fifo_empty, pop;
  logic [FW-1:0]    fifo_rdata;
  job_t             new_job, head_job;
  logic [TAG_W-1:0] head_tag;
  logic             unused_pad;

  assign last_byte = (byte_cnt_q == 3'(JOB_BYTES - 1));
  // Registered full: a pop in the same cycle does not admit the last byte.
  assign in_ready  = !last_byte || !fifo_full;
  assign b_acc     = in_valid && in_ready;
  assign new_job   = '{central: central_q,
                       radius:  {rad_hi_q, in_data[7:4]},
                       mode:    in_data[1:0]};
  assign push      = b_acc && last_byte && mode_ok(in_data[1:0]);
  assign err_mode  = err_q;
  assign unused_pad = ^in_data[3:2];

  // Collect descriptor bytes; tag advances only for accepted jobs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      byte_cnt_q <= '0;
      central_q  <= '0;
      rad_hi_q   <= '0;
      in_tag_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (b_acc) begin
        case (byte_cnt_q)
          3'd0:    central_q[23:16] <= in_data;
          3'd1:    central_q[15:8]  <= in_data;
          3'd2:    central_q[7:0]   <= in_data;
          3'd3:    rad_hi_q         <= in_data;
          default: ;
        endcase
        byte_cnt_q <= last_byte ? 3'd0 : byte_cnt_q + 3'd1;
        if (last_byte) begin
          if (mode_ok(in_data[1:0])) in_tag_q <= in_tag_q + 1'b1;
          else                       err_q    <= 1'b1;
        end
      end
    end
  end

  set_job_fifo #(.DEPTH(DEPTH), .W(FW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i ({in_tag_q, new_job}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign head_job = fifo_rdata[JOB_W-1:0];
  assign head_tag = fifo_rdata[JOB_W +: TAG_W];

  // ---------------- dispatcher ----------------
  disp_e            state_q, state_d;
  job_t             last_job_q;
  logic [TAG_W-1:0] run_tag_q, run_tag_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;
  logic [7:0]       res_cand_q, res_cand_d;
  logic             res_valid_q, res_valid_d;
  logic             job_ready;

  // A push this cycle counts as non-empty so an idle SET sees en next cycle.
  assign job_ready = !fifo_empty || push;

`ifdef SET_LDR_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            res_to_q, res_to_d;
  assign res_timeout = res_to_q;
`else
  logic unused_timeout;
  assign res_timeout    = 1'b0;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  // Dispatcher next-state and strobes.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    set_en      = 1'b0;
    run_tag_d   = run_tag_q;
    res_tag_d   = res_tag_q;
    res_cand_d  = res_cand_q;
    res_valid_d = res_valid_q;
`ifdef SET_LDR_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
    res_to_d    = res_to_q;
`endif
    case (state_q)
      D_IDLE: if (job_ready) state_d = D_ISSUE;
      D_ISSUE: begin
        if (!set_busy) begin
          set_en    = 1'b1;
          pop       = 1'b1;
          run_tag_d = head_tag;
          state_d   = D_WAIT;
`ifdef SET_LDR_TIMEOUT_EN
          // Counted from the set_en cycle.
          to_cnt_d  = TO_W'(1);
`endif
        end
      end
      D_WAIT: begin
        if (set_valid) begin
          res_cand_d  = set_candidate;
          res_tag_d   = run_tag_q;
          res_valid_d = 1'b1;
          state_d     = D_HOLD;
`ifdef SET_LDR_TIMEOUT_EN
          res_to_d    = 1'b0;
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          res_cand_d  = 8'hFF;
          res_tag_d   = run_tag_q;
          res_valid_d = 1'b1;
          res_to_d    = 1'b1;
          state_d     = D_HOLD;
        end else begin
          to_cnt_d    = to_cnt_q + 1'b1;
`endif
        end
      end
      D_HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = job_ready ? D_ISSUE : D_IDLE;
        end
      end
      default: state_d = D_IDLE;
    endcase
  end

  // Dispatcher registers; SET-side outputs remember the last issued head.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= D_IDLE;
      last_job_q  <= '0;
      run_tag_q   <= '0;
      res_tag_q   <= '0;
      res_cand_q  <= '0;
      res_valid_q <= 1'b0;
`ifdef SET_LDR_TIMEOUT_EN
      to_cnt_q    <= '0;
      res_to_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      run_tag_q   <= run_tag_d;
      res_tag_q   <= res_tag_d;
      res_cand_q  <= res_cand_d;
      res_valid_q <= res_valid_d;
      if (state_q == D_ISSUE) last_job_q <= head_job;
`ifdef SET_LDR_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
      res_to_q    <= res_to_d;
`endif
    end
  end

  assign set_central   = (state_q == D_ISSUE) ? head_job.central : last_job_q.central;
  assign set_radius    = (state_q == D_ISSUE) ? head_job.radius  : last_job_q.radius;
  assign set_mode      = (state_q == D_ISSUE) ? head_job.mode    : last_job_q.mode;
  assign res_valid     = res_valid_q;
  assign res_candidate = res_cand_q;
  assign res_tag       = res_tag_q;

endmodule

// File: tb/tb_set_job_loader.sv
// Directed bench for set_job_loader with a small behavioural SET engine
// (8x8 grid circle counter) answering each set_en after a few busy cycles.
module tb_set_job_loader;

  localparam int DEPTH = 4, TAG_W = 4, TIMEOUT = 256;
  localparam logic [39:0] J1 = 40'h44_00_00_30_02;  // centre (4,4) r=3 -> 29

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, in_ready, set_busy, set_valid, set_en, res_valid, res_ready;
  logic res_timeout, err_mode;
  logic [7:0] in_data, set_candidate, res_candidate;
  logic [23:0] set_central;
  logic [11:0] set_radius;
  logic [1:0] set_mode;
  logic [TAG_W-1:0] res_tag;
  logic [2:0] fifo_level;

  logic stub_busy, hold_busy;
  logic stub_never = 1'b0;
  int   en_cnt = 0;
  int   errs = 0, checks = 0;
  assign set_busy = stub_busy | hold_busy;

  set_job_loader #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .set_busy(set_busy), .set_valid(set_valid), .set_candidate(set_candidate),
    .set_en(set_en), .set_central(set_central), .set_radius(set_radius), .set_mode(set_mode),
    .res_valid(res_valid), .res_ready(res_ready), .res_candidate(res_candidate),
    .res_tag(res_tag), .res_timeout(res_timeout), .err_mode(err_mode), .fifo_level(fifo_level)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_to(input string name);
    checks++;
    errs++;
    $display("FAIL %s: timed out", name);
  endtask

  // SET behaviour: points of the 8x8 grid inside circle A, A&B or A^B.
  function automatic logic [7:0] set_count(input logic [23:0] c, input logic [11:0] r,
                                           input logic [1:0] m);
    int xa, ya, xb, yb, ra, rb, n;
    bit ia, ib, hit;
    xa = int'(c[23:20]); ya = int'(c[19:16]); xb = int'(c[15:12]); yb = int'(c[11:8]);
    ra = int'(r[11:8]);  rb = int'(r[7:4]);   n = 0;
    for (int x = 1; x <= 8; x++)
      for (int y = 1; y <= 8; y++) begin
        ia = ((x-xa)*(x-xa) + (y-ya)*(y-ya)) <= ra*ra;
        ib = ((x-xb)*(x-xb) + (y-yb)*(y-yb)) <= rb*rb;
        hit = (m == 2'd0) ? ia : (m == 2'd1) ? (ia & ib) : (ia ^ ib);
        if (hit) n++;
      end
    return 8'(n);
  endfunction

  // SET stub: busy for 3 cycles after en, then one set_valid pulse.
  initial begin
    logic [7:0] cand;
    stub_busy = 1'b0; set_valid = 1'b0; set_candidate = 8'h00;
    forever begin
      @(negedge clk);
      if (set_en) begin
        en_cnt++;
        if (!stub_never) begin
          cand = set_count(set_central, set_radius, set_mode);
          @(posedge clk); #1 stub_busy = 1'b1;
          repeat (3) @(posedge clk);
          #1 set_valid = 1'b1; set_candidate = cand;
          @(posedge clk); #1 set_valid = 1'b0; set_candidate = 8'h00; stub_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // All driving tasks start and end at #1 after a rising edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1; in_data = b;
    @(negedge clk);
    while (!in_ready && n < 2000) begin @(negedge clk); n++; end
    if (!in_ready) fail_to("in_ready");
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic send_job(input logic [39:0] bytes);
    for (int k = 0; k < 5; k++) send_byte(bytes[39-8*k -: 8]);
  endtask

  task automatic wait_res(input string name, input int lim, output int n);
    bit ok = 0;
    n = 0;
    while (n < lim && !ok) begin
      @(negedge clk); n++;
      if (res_valid) ok = 1;
    end
    if (!ok) fail_to(name);
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(posedge clk); #1 res_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
  endtask

  typedef struct packed {
    logic [39:0] bytes;
    logic        is_err;
    logic [7:0]  cand;
    logic [3:0]  tag;
  } vec_t;

  initial begin
    vec_t vecs [6];
    int e0, n, bad;
    logic [39:0] bb;

    vecs[0] = '{J1,                 1'b0, 8'd29, 4'd0};
    vecs[1] = '{40'h11_00_00_20_00, 1'b0, 8'd6,  4'd1};  // (1,1) r=2 corner
    vecs[2] = '{40'h11_22_33_44_03, 1'b1, 8'd0,  4'd0};  // mode 3 dropped
    vecs[3] = '{40'h44_54_00_22_01, 1'b0, 8'd8,  4'd2};  // A&B, (4,4),(5,4) r=2
    vecs[4] = '{40'h44_54_00_22_02, 1'b0, 8'd10, 4'd3};  // A^B
    vecs[5] = '{40'h88_00_00_10_00, 1'b0, 8'd3,  4'd4};  // (8,8) r=1 corner

    rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; res_ready = 1'b0; hold_busy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_set_en",   32'(set_en), 32'd0);
    chk("rst_set_job",  32'({set_central, set_radius, set_mode}), 32'd0);
    chk("rst_res",      32'({res_valid, res_candidate, res_tag, res_timeout}), 32'd0);
    chk("rst_err_mode", 32'(err_mode), 32'd0);
    chk("rst_level",    32'(fifo_level), 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    // ---- table: one job at a time, SET idle ----
    for (int i = 0; i < 6; i++) begin
      e0 = en_cnt;
      bb = vecs[i].bytes;
      send_job(bb);
      @(negedge clk);
      if (vecs[i].is_err) begin
        chk($sformatf("v%0d_err_mode", i), 32'(err_mode), 32'd1);
        chk($sformatf("v%0d_level", i), 32'(fifo_level), 32'd0);
        @(negedge clk);
        chk($sformatf("v%0d_err_pulse", i), 32'(err_mode), 32'd0);
        repeat (5) @(posedge clk);
        #1 chk($sformatf("v%0d_no_en", i), en_cnt - e0, 32'd0);
      end else begin
        chk($sformatf("v%0d_en_latency", i), 32'(set_en), 32'd1);
        chk($sformatf("v%0d_central", i), 32'(set_central), 32'(bb[39:16]));
        chk($sformatf("v%0d_radmode", i), 32'({set_radius, set_mode}),
            32'({bb[15:8], bb[7:4], bb[1:0]}));
        wait_res($sformatf("v%0d_res", i), 100, n);
        chk($sformatf("v%0d_cand", i), 32'(res_candidate), 32'(vecs[i].cand));
        chk($sformatf("v%0d_tag", i), 32'(res_tag), 32'(vecs[i].tag));
        chk($sformatf("v%0d_timeout", i), 32'(res_timeout), 32'd0);
        consume();
        chk($sformatf("v%0d_en_cnt", i), en_cnt - e0, 32'd1);
      end
    end

    // ---- five jobs while SET busy: backpressure on the 5th job's b4 ----
    do_reset();
    hold_busy = 1'b1;
    e0 = en_cnt;
    for (int j = 0; j < 4; j++) send_job(J1);
    for (int k = 0; k < 4; k++) send_byte(J1[39-8*k -: 8]);
    in_valid = 1'b1; in_data = J1[7:0];
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("full_ready_%0d", k), 32'(in_ready), 32'd0);
    end
    chk("full_level", 32'(fifo_level), 32'd4);
    chk("busy_no_en", en_cnt - e0, 32'd0);
    @(posedge clk); #1 hold_busy = 1'b0;
    @(negedge clk);
    chk("pop_cycle_ready", 32'(in_ready), 32'd0);
    chk("pop_cycle_en", 32'(set_en), 32'd1);
    @(negedge clk);
    chk("after_pop_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    for (int t = 0; t < 5; t++) begin
      wait_res($sformatf("burst_res%0d", t), 100, n);
      chk($sformatf("burst_tag%0d", t), 32'(res_tag), 32'(t));
      chk($sformatf("burst_cand%0d", t), 32'(res_candidate), 32'd29);
      consume();
    end
    chk("burst_en_cnt", en_cnt - e0, 32'd5);

    // ---- result held unconsumed for 500 cycles ----
    e0 = en_cnt;
    send_job(J1);
    send_job(J1);
    wait_res("hold_res", 100, n);
    bad = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (!res_valid || res_candidate != 8'd29 || res_tag != 4'd5 || set_en ||
          fifo_level != 3'd1) bad++;
    end
    chk("hold_stable_bad_cycles", bad, 32'd0);
    @(posedge clk); #1 chk("hold_en_cnt", en_cnt - e0, 32'd1);
    @(negedge clk);
    consume();
    wait_res("hold_res2", 100, n);
    chk("hold_tag2", 32'(res_tag), 32'd6);
    consume();

    // ---- reset during b2 with two jobs queued ----
    hold_busy = 1'b1;
    send_job(J1);
    send_job(J1);
    @(negedge clk);
    chk("pre_rst_level", 32'(fifo_level), 32'd2);
    @(posedge clk); #1;
    send_byte(8'h11);
    send_byte(8'h00);
    in_valid = 1'b1; in_data = 8'h00;
    rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1; in_valid = 1'b0; hold_busy = 1'b0;
    @(negedge clk);
    chk("mid_rst_level", 32'(fifo_level), 32'd0);
    chk("mid_rst_set",   32'({set_en, set_central, set_radius, set_mode}), 32'd0);
    chk("mid_rst_res",   32'({res_valid, res_candidate, res_tag, res_timeout, err_mode}), 32'd0);
    @(posedge clk); #1;
    send_job(J1);
    @(negedge clk);
    chk("post_rst_en", 32'(set_en), 32'd1);
    wait_res("post_rst_res", 100, n);
    chk("post_rst_cand", 32'(res_candidate), 32'd29);
    chk("post_rst_tag", 32'(res_tag), 32'd0);
    consume();

`ifdef SET_LDR_TIMEOUT_EN
    // ---- SET never answers: timeout result ----
    stub_never = 1'b1;
    send_job(J1);
    @(negedge clk);
    chk("to_en", 32'(set_en), 32'd1);
    wait_res("to_res", 400, n);
    chk("to_latency", n, 32'd256);
    chk("to_cand", 32'(res_candidate), 32'hFF);
    chk("to_flag", 32'(res_timeout), 32'd1);
    chk("to_tag", 32'(res_tag), 32'd1);
    consume();
    stub_never = 1'b0;
    send_job(J1);
    wait_res("to_next_res", 100, n);
    chk("to_next_flag", 32'(res_timeout), 32'd0);
    chk("to_next_cand", 32'(res_candidate), 32'd29);
    consume();
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
